// File: rtl/sr_latch_ctrl_pkg.sv
// sr_latch_ctrl_pkg: FSM state encodings, op codes and a clog2 helper for sr_latch_ctrl
package sr_latch_ctrl_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_SETTLE, ST_DONE} state_t;
    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/sr_latch_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr (wrapping)
module rr_arbiter
    import sr_latch_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PW-1:0]    gidx,
    output logic             any
);
    // scan downwards so the lowest offset from ptr is the final winner
    always_comb begin
        gidx = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N_REQ]) gidx = PW'((int'(ptr) + k) % N_REQ);
        any = |req;
        gnt = any ? N_REQ'(1) << gidx : '0;
    end
endmodule

// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: round-robin serialised s/r pulse driver for a NOR SR latch bank (optional q readback via SR_LATCH_CTRL_READBACK_EN)
module sr_latch_ctrl
    import sr_latch_ctrl_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int N_FLAG     = 8,
    parameter int IDXW       = 3,
    parameter int PULSE_CYC  = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic                   clock,
    input  logic                   reset_,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       op,
    input  logic [N_REQ*IDXW-1:0]  idx,
    output logic [N_REQ-1:0]       ack,
    output logic                   err,
    output logic                   busy,
    output logic [N_FLAG-1:0]      s_out,
    output logic [N_FLAG-1:0]      r_out,
    input  logic [N_FLAG-1:0]      q_in
);
    localparam int PW = clog2(N_REQ);
    localparam int CW = clog2(PULSE_CYC > SETTLE_CYC ? PULSE_CYC : SETTLE_CYC) + 1;

    state_t            state;
    logic [PW-1:0]     ptr, gidx;
    logic [N_REQ-1:0]  gnt, g_oh;
    logic              any, c_op, fail;
    logic [IDXW-1:0]   c_idx, g_sel;
    logic [N_FLAG-1:0] g_mask, c_mask;
    logic [CW-1:0]     cnt;

    rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req  (req),
        .ptr  (ptr),
        .gnt  (gnt),
        .gidx (gidx),
        .any  (any)
    );

    // an index beyond the bank shifts the one-hot mask to zero, which doubles as the range check
    assign g_sel  = idx[gidx*IDXW +: IDXW];
    assign g_mask = N_FLAG'(1) << g_sel;
    assign c_mask = N_FLAG'(1) << c_idx;

`ifdef SR_LATCH_CTRL_READBACK_EN
    assign fail = ~|c_mask || ((|(q_in & c_mask)) != (c_op == OP_SET));
`else
    logic unused_q;
    assign unused_q = ^q_in;
    assign fail     = ~|c_mask;
`endif

    // FSM with registered drive and handshake; drive clears by default so s/r only exist in PULSE
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= ST_IDLE;
            ptr   <= '0;
            cnt   <= '0;
            g_oh  <= '0;
            c_op  <= 1'b0;
            c_idx <= '0;
            ack   <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
            s_out <= '0;
            r_out <= '0;
        end else begin
            ack   <= '0;
            err   <= 1'b0;
            s_out <= '0;
            r_out <= '0;
            case (state)
                ST_IDLE: if (any) begin
                    state <= ST_PULSE;
                    g_oh  <= gnt;
                    c_op  <= op[gidx];
                    c_idx <= g_sel;
                    ptr   <= (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    s_out <= (op[gidx] == OP_SET)   ? g_mask : '0;
                    r_out <= (op[gidx] == OP_RESET) ? g_mask : '0;
                end
                ST_PULSE: if (cnt == CW'(PULSE_CYC - 1)) begin
                    state <= ST_SETTLE;
                    cnt   <= '0;
                end else begin
                    s_out <= s_out;
                    r_out <= r_out;
                    cnt   <= cnt + 1'b1;
                end
                ST_SETTLE: if (cnt == CW'(SETTLE_CYC - 1)) begin
                    state <= ST_DONE;
                    ack   <= g_oh;
                    err   <= fail;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
